tcdm_amo_adapter: RTL and testbench

TCDM_AMO_ADAPTER -- requirements
Module: tcdm_amo_adapter

---
 rtl/mempool_pkg.sv | 30 +++
 rtl/amo_alu.sv | 32 +++
 rtl/tcdm_amo_adapter.sv | 188 ++++++++++++++++++
 tb/tb_tcdm_amo_adapter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mempool_pkg.sv
// Shared definitions for the TCDM atomic-memory-operation adapter:
// the AMO operation codes and the adapter FSM state type.
package mempool_pkg;

   typedef enum logic [3:0] {
      AMO_NONE = 4'h0,
      AMO_SWAP = 4'h1,
      AMO_ADD  = 4'h2,
      AMO_AND  = 4'h3,
      AMO_OR   = 4'h4,
      AMO_XOR  = 4'h5,
      AMO_MAX  = 4'h6,
      AMO_MAXU = 4'h7,
      AMO_MIN  = 4'h8,
      AMO_MINU = 4'h9,
      AMO_LR   = 4'hA,
      AMO_SC   = 4'hB
   } amo_t;

   typedef enum logic {
      IDLE   = 1'b0,
      AMO_WB = 1'b1
   } adapter_state_t;

   // Read-modify-write codes; LR/SC and the unused codes C-F are excluded.
   function automatic logic is_rmw(input logic [3:0] code);
      return (code >= AMO_SWAP) && (code <= AMO_MINU);
   endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic: computes the value written back by a
// read-modify-write from the old memory word and the request operand.
module amo_alu import mempool_pkg::*; (
   input  logic [31:0] old_data,
   input  logic [31:0] operand,
   input  logic [3:0]  code,
   output logic [31:0] new_data
);

   logic signed_lt;
   logic unsigned_lt;

   assign signed_lt   = $signed(old_data) < $signed(operand);
   assign unsigned_lt = old_data < operand;

   always_comb begin
      new_data = old_data;
      case (code)
         AMO_SWAP: new_data = operand;
         AMO_ADD:  new_data = old_data + operand;
         AMO_AND:  new_data = old_data & operand;
         AMO_OR:   new_data = old_data | operand;
         AMO_XOR:  new_data = old_data ^ operand;
         AMO_MAX:  new_data = signed_lt   ? operand  : old_data;
         AMO_MAXU: new_data = unsigned_lt ? operand  : old_data;
         AMO_MIN:  new_data = signed_lt   ? old_data : operand;
         AMO_MINU: new_data = unsigned_lt ? old_data : operand;
         default:  new_data = old_data;
      endcase
   end

endmodule

// File: rtl/tcdm_amo_adapter.sv
// Sits in front of a single-port SRAM bank and turns AMO, LR/SC and plain
// requests into bank reads/writes, with one reservation and a response skid.
module tcdm_amo_adapter import mempool_pkg::*; #(
   parameter int unsigned AddrMemWidth = 8,
   parameter int unsigned MetaWidth    = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // Request: a transfer happens on a cycle with in_valid_i && in_ready_o;
   // response: a transfer happens on a cycle with out_valid_o && out_ready_i.
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [AddrMemWidth-1:0] in_addr_i,
   input  logic                    in_wen_i,
   input  logic [3:0]              in_be_i,
   input  logic [3:0]              in_amo_i,
   input  logic [31:0]             in_data_i,
   input  logic [MetaWidth-1:0]    in_meta_i,
   input  logic [3:0]              in_core_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             out_rdata_o,
   output logic [MetaWidth-1:0]    out_meta_o,
   output logic                    bank_req_o,
   output logic                    bank_we_o,
   output logic [AddrMemWidth-1:0] bank_addr_o,
   output logic [31:0]             bank_wdata_o,
   output logic [3:0]              bank_be_o,
   input  logic [31:0]             bank_rdata_i
);

   adapter_state_t state_q, state_d;

   logic [3:0]              code_q;
   logic [31:0]             operand_q;
   logic [AddrMemWidth-1:0] addr_q;

   logic                    res_valid_q, res_valid_d;
   logic [AddrMemWidth-1:0] res_addr_q, res_addr_d;
   logic [3:0]              res_core_q, res_core_d;

   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_from_bank_q, rsp_from_bank_d;
   logic [31:0]             rsp_const_q, rsp_const_d;
   logic [MetaWidth-1:0]    rsp_meta_q, rsp_meta_d;

   logic                    hold_valid_q;
   logic [31:0]             hold_data_q;
   logic [MetaWidth-1:0]    hold_meta_q;

   logic        accept;
   logic        is_rmw_req;
   logic        is_lr;
   logic        is_sc;
   logic        is_plain_wr;
   logic        res_hit;
   logic        sc_ok;
   logic [31:0] rsp_data;
   logic [31:0] amo_new;

   assign is_rmw_req  = is_rmw(in_amo_i);
   assign is_lr       = (in_amo_i == AMO_LR);
   assign is_sc       = (in_amo_i == AMO_SC);
   assign is_plain_wr = !is_rmw_req && !is_lr && !is_sc && in_wen_i;
   assign res_hit     = res_valid_q && (res_addr_q == in_addr_i);
   assign sc_ok       = is_sc && res_hit && (res_core_q == in_core_i);

   // A response that is presented but refused this cycle blocks new requests.
   assign in_ready_o  = !rst_i && (state_q == IDLE) && !hold_valid_q &&
                        !(rsp_valid_q && !out_ready_i);
   assign accept      = in_valid_i && in_ready_o;

   assign out_valid_o = !rst_i && (hold_valid_q || rsp_valid_q);

   amo_alu u_amo_alu (
      .old_data (bank_rdata_i),
      .operand  (operand_q),
      .code     (code_q),
      .new_data (amo_new)
   );

   always_comb begin
      rsp_data    = rsp_from_bank_q ? bank_rdata_i : rsp_const_q;
      out_rdata_o = '0;
      out_meta_o  = '0;
      if (hold_valid_q) begin
         out_rdata_o = hold_data_q;
         out_meta_o  = hold_meta_q;
      end else if (rsp_valid_q) begin
         out_rdata_o = rsp_data;
         out_meta_o  = rsp_meta_q;
      end
   end

   always_comb begin
      state_d         = state_q;
      bank_req_o      = 1'b0;
      bank_we_o       = 1'b0;
      bank_addr_o     = in_addr_i;
      bank_wdata_o    = in_data_i;
      bank_be_o       = 4'hF;
      res_valid_d     = res_valid_q;
      res_addr_d      = res_addr_q;
      res_core_d      = res_core_q;
      rsp_valid_d     = 1'b0;
      rsp_from_bank_d = 1'b1;
      rsp_const_d     = '0;
      rsp_meta_d      = in_meta_i;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rsp_valid_d = !is_plain_wr;
               if (is_sc) begin
                  rsp_from_bank_d = 1'b0;
                  rsp_const_d     = {31'b0, !sc_ok};
                  bank_req_o      = sc_ok;
                  bank_we_o       = sc_ok;
                  if (sc_ok || (res_core_q == in_core_i)) res_valid_d = 1'b0;
               end else begin
                  bank_req_o = 1'b1;
                  bank_we_o  = is_plain_wr;
                  if (is_plain_wr) bank_be_o = in_be_i;
                  if (is_plain_wr && res_hit) res_valid_d = 1'b0;
                  if (is_lr) begin
                     res_valid_d = 1'b1;
                     res_addr_d  = in_addr_i;
                     res_core_d  = in_core_i;
                  end
                  if (is_rmw_req) state_d = AMO_WB;
               end
            end
         end
         AMO_WB: begin
            // Old value arrives from the bank this cycle; write the result back.
            state_d      = IDLE;
            bank_req_o   = !rst_i;
            bank_we_o    = !rst_i;
            bank_addr_o  = addr_q;
            bank_wdata_o = amo_new;
            if (res_valid_q && (res_addr_q == addr_q)) res_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         code_q          <= '0;
         operand_q       <= '0;
         addr_q          <= '0;
         res_valid_q     <= 1'b0;
         res_addr_q      <= '0;
         res_core_q      <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_from_bank_q <= 1'b0;
         rsp_const_q     <= '0;
         rsp_meta_q      <= '0;
         hold_valid_q    <= 1'b0;
         hold_data_q     <= '0;
         hold_meta_q     <= '0;
      end else begin
         state_q         <= state_d;
         res_valid_q     <= res_valid_d;
         res_addr_q      <= res_addr_d;
         res_core_q      <= res_core_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_from_bank_q <= rsp_from_bank_d;
         rsp_const_q     <= rsp_const_d;
         rsp_meta_q      <= rsp_meta_d;
         if (accept) begin
            code_q    <= in_amo_i;
            operand_q <= in_data_i;
            addr_q    <= in_addr_i;
         end
         // The bank read data is only valid for one cycle, so a refused
         // response is frozen here until the consumer takes it.
         if (hold_valid_q) begin
            if (out_ready_i) hold_valid_q <= 1'b0;
         end else if (rsp_valid_q && !out_ready_i) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= rsp_data;
            hold_meta_q  <= rsp_meta_q;
         end
      end
   end

endmodule

// File: tb/tb_tcdm_amo_adapter.sv
// Bench for tcdm_amo_adapter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a word-level reference model.
module tb_tcdm_amo_adapter;

   localparam int AW = 8;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic          in_wen = 1'b0;
   logic [3:0]    in_be = '0;
   logic [3:0]    in_amo = '0;
   logic [31:0]   in_data = '0;
   logic [MW-1:0] in_meta = '0;
   logic [3:0]    in_core = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_rdata;
   logic [MW-1:0] out_meta;
   logic          bank_req;
   logic          bank_we;
   logic [AW-1:0] bank_addr;
   logic [31:0]   bank_wdata;
   logic [3:0]    bank_be;
   logic [31:0]   bank_rdata = '0;

   int checks = 0;
   int errors = 0;

   tcdm_amo_adapter #(.AddrMemWidth(AW), .MetaWidth(MW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_addr_i    (in_addr),
      .in_wen_i     (in_wen),
      .in_be_i      (in_be),
      .in_amo_i     (in_amo),
      .in_data_i    (in_data),
      .in_meta_i    (in_meta),
      .in_core_i    (in_core),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_rdata_o  (out_rdata),
      .out_meta_o   (out_meta),
      .bank_req_o   (bank_req),
      .bank_we_o    (bank_we),
      .bank_addr_o  (bank_addr),
      .bank_wdata_o (bank_wdata),
      .bank_be_o    (bank_be),
      .bank_rdata_i (bank_rdata)
   );

   // ---------------- clock and SRAM bank model ----------------
   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bank_req && bank_we)
         for (int b = 0; b < 4; b++)
            if (bank_be[b]) mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
      if (bank_req && !bank_we) bank_rdata <= mem[bank_addr];
   end

   // ---------------- checking helpers ----------------
   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [3:0] amo, input logic [AW-1:0] addr, input logic wen,
                        input logic [3:0] be, input logic [31:0] data, input logic [3:0] core,
                        input logic [MW-1:0] meta);
      int n;
      n = 0;
      in_valid = 1'b1; in_amo = amo; in_addr = addr; in_wen = wen;
      in_be = be; in_data = data; in_core = core; in_meta = meta;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("issue_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]    amo;
      logic [AW-1:0] addr;
      logic          wen;
      logic [3:0]    be;
      logic [31:0]   data;
      logic [3:0]    core;
      logic          rsp;
      logic [31:0]   exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] amo, input logic [AW-1:0] addr, input logic wen,
                               input logic [3:0] be, input logic [31:0] data, input logic [3:0] core,
                               input logic rsp, input logic [31:0] exp);
      vec_t v;
      v.amo = amo; v.addr = addr; v.wen = wen; v.be = be;
      v.data = data; v.core = core; v.rsp = rsp; v.exp = exp;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      issue(v.amo, v.addr, v.wen, v.be, v.data, v.core, MW'(idx));
      @(negedge clk);
      chk1($sformatf("vec%0d_valid", idx), out_valid, v.rsp);
      if (v.rsp) begin
         chk32($sformatf("vec%0d_rdata", idx), out_rdata, v.exp);
         chk32($sformatf("vec%0d_meta", idx), 32'(out_meta), 32'(idx));
      end
      @(posedge clk); #1;
   endtask

   // ---------------- reference model for random traffic ----------------
   logic [31:0] ref_mem [0:15];
   logic        ref_res_v;
   logic [3:0]  ref_res_a;
   logic [3:0]  ref_res_c;
   logic [39:0] exp_q[$];
   logic        acc_last;
   logic        stall_seen;
   logic [39:0] stall_val;

   function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         4'h1: return b;
         4'h2: return a + b;
         4'h3: return a & b;
         4'h4: return a | b;
         4'h5: return a ^ b;
         4'h6: return (sa > sb) ? a : b;
         4'h7: return (a > b) ? a : b;
         4'h8: return (sa < sb) ? a : b;
         4'h9: return (a < b) ? a : b;
         default: return a;
      endcase
   endfunction

   task automatic model_accept();
      logic [3:0]  a;
      logic [31:0] old;
      a = in_addr[3:0];
      old = ref_mem[a];
      if (in_amo >= 4'h1 && in_amo <= 4'h9) begin
         exp_q.push_back({in_meta, old});
         ref_mem[a] = amo_ref(in_amo, old, in_data);
         if (ref_res_v && ref_res_a == a) ref_res_v = 1'b0;
      end else if (in_amo == 4'hA) begin
         exp_q.push_back({in_meta, old});
         ref_res_v = 1'b1; ref_res_a = a; ref_res_c = in_core;
      end else if (in_amo == 4'hB) begin
         if (ref_res_v && ref_res_a == a && ref_res_c == in_core) begin
            ref_mem[a] = in_data;
            exp_q.push_back({in_meta, 32'd0});
            ref_res_v = 1'b0;
         end else begin
            exp_q.push_back({in_meta, 32'd1});
            if (ref_res_c == in_core) ref_res_v = 1'b0;
         end
      end else if (in_wen) begin
         for (int b = 0; b < 4; b++)
            if (in_be[b]) ref_mem[a][8*b +: 8] = in_data[8*b +: 8];
         if (ref_res_v && ref_res_a == a) ref_res_v = 1'b0;
      end else begin
         exp_q.push_back({in_meta, old});
      end
   endtask

   // One negedge of observation: response scoreboard, stall stability, model.
   task automatic mon_cycle();
      logic [39:0] e;
      @(negedge clk);
      if (stall_seen) begin
         chk1("stall_valid", out_valid, 1'b1);
         chk32("stall_rdata", out_rdata, stall_val[31:0]);
         chk32("stall_meta", 32'(out_meta), 32'(stall_val[39:32]));
      end
      if (out_valid) begin
         if (out_ready) begin
            stall_seen = 1'b0;
            chk1("rsp_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk32("rsp_rdata", out_rdata, e[31:0]);
               chk32("rsp_meta", 32'(out_meta), 32'(e[39:32]));
            end
         end else begin
            stall_seen = 1'b1;
            stall_val  = {out_meta, out_rdata};
         end
      end
      acc_last = in_valid && in_ready;
      if (acc_last) model_accept();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int preload;
      int low_cnt;

      // Reset and reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_bank_req", bank_req, 1'b0);
      chk1("rst_bank_we", bank_we, 1'b0);
      chk32("rst_rdata", out_rdata, 32'h0);
      chk32("rst_meta", 32'(out_meta), 32'h0);
      @(posedge clk); #1;

      //          amo    addr   wen   be     data            core  rsp   expected
      vecs.push_back(mk(4'h0, 8'd5, 1'b1, 4'hF, 32'h12345678, 4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'h0, 8'd5, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'h12345678));
      vecs.push_back(mk(4'h0, 8'd3, 1'b1, 4'hF, 32'd10,       4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'h2, 8'd3, 1'b0, 4'hF, 32'hFFFFFFFF, 4'd0, 1'b1, 32'd10));
      vecs.push_back(mk(4'h0, 8'd3, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'd9));
      vecs.push_back(mk(4'h0, 8'd7, 1'b1, 4'hF, 32'hFFFFFFFE, 4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'h6, 8'd7, 1'b0, 4'hF, 32'd1,        4'd0, 1'b1, 32'hFFFFFFFE));
      vecs.push_back(mk(4'h0, 8'd7, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'd1));
      vecs.push_back(mk(4'h0, 8'd7, 1'b1, 4'hF, 32'hFFFFFFFE, 4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'h7, 8'd7, 1'b0, 4'hF, 32'd1,        4'd0, 1'b1, 32'hFFFFFFFE));
      vecs.push_back(mk(4'h0, 8'd7, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'hFFFFFFFE));
      vecs.push_back(mk(4'h8, 8'd7, 1'b0, 4'hF, 32'd1,        4'd0, 1'b1, 32'hFFFFFFFE));
      vecs.push_back(mk(4'h9, 8'd7, 1'b0, 4'hF, 32'd1,        4'd0, 1'b1, 32'hFFFFFFFE));
      vecs.push_back(mk(4'h0, 8'd7, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'd1));
      vecs.push_back(mk(4'h1, 8'd7, 1'b0, 4'hF, 32'hDEADBEEF, 4'd0, 1'b1, 32'd1));
      vecs.push_back(mk(4'h5, 8'd7, 1'b0, 4'hF, 32'hFFFF0000, 4'd0, 1'b1, 32'hDEADBEEF));
      vecs.push_back(mk(4'h0, 8'd7, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'h2152BEEF));
      vecs.push_back(mk(4'h0, 8'd9, 1'b1, 4'hF, 32'h0,        4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'hA, 8'd9, 1'b0, 4'hF, 32'h0,        4'd2, 1'b1, 32'h0));
      vecs.push_back(mk(4'hB, 8'd9, 1'b0, 4'hF, 32'hAA,       4'd2, 1'b1, 32'd0));
      vecs.push_back(mk(4'h0, 8'd9, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'hAA));
      vecs.push_back(mk(4'hB, 8'd9, 1'b0, 4'hF, 32'hBB,       4'd2, 1'b1, 32'd1));
      vecs.push_back(mk(4'h0, 8'd9, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'hAA));
      vecs.push_back(mk(4'hA, 8'd9, 1'b0, 4'hF, 32'h0,        4'd2, 1'b1, 32'hAA));
      vecs.push_back(mk(4'h0, 8'd9, 1'b1, 4'hF, 32'h55,       4'd1, 1'b0, 32'h0));
      vecs.push_back(mk(4'hB, 8'd9, 1'b0, 4'hF, 32'hCC,       4'd2, 1'b1, 32'd1));
      vecs.push_back(mk(4'h0, 8'd9, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'h55));
      vecs.push_back(mk(4'h0, 8'd5, 1'b1, 4'h5, 32'hAABBCCDD, 4'd0, 1'b0, 32'h0));
      vecs.push_back(mk(4'h0, 8'd5, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'h12BB56DD));
      vecs.push_back(mk(4'hC, 8'd5, 1'b0, 4'hF, 32'h0,        4'd0, 1'b1, 32'h12BB56DD));
      foreach (vecs[i]) run_vec(vecs[i], i);

      // AMO ADD: write-back of old+operand in the response cycle, ready low once
      issue(4'h0, 8'd3, 1'b1, 4'hF, 32'd10, 4'd0, 8'h00);
      issue(4'h2, 8'd3, 1'b0, 4'hF, 32'hFFFFFFFF, 4'd0, 8'h38);
      @(negedge clk);
      chk1("add_valid", out_valid, 1'b1);
      chk32("add_rdata", out_rdata, 32'd10);
      chk32("add_meta", 32'(out_meta), 32'h38);
      chk1("add_wb_req", bank_req, 1'b1);
      chk1("add_wb_we", bank_we, 1'b1);
      chk32("add_wb_addr", 32'(bank_addr), 32'd3);
      chk32("add_wb_data", bank_wdata, 32'd9);
      chk32("add_wb_be", 32'(bank_be), 32'hF);
      low_cnt = 0;
      while (!in_ready && low_cnt < 10) begin
         low_cnt++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk32("add_ready_low_cycles", 32'(low_cnt), 32'd1);
      chk32("add_mem3", mem[3], 32'd9);
      @(posedge clk); #1;

      // Response refused for three cycles, then released
      out_ready = 1'b0;
      issue(4'h0, 8'd5, 1'b0, 4'hF, 32'h0, 4'd0, 8'h5A);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1($sformatf("stall%0d_valid", k), out_valid, 1'b1);
         chk32($sformatf("stall%0d_rdata", k), out_rdata, 32'h12BB56DD);
         chk32($sformatf("stall%0d_meta", k), 32'(out_meta), 32'h5A);
         chk1($sformatf("stall%0d_ready", k), in_ready, 1'b0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk1("release_valid", out_valid, 1'b1);
      chk32("release_rdata", out_rdata, 32'h12BB56DD);
      chk1("release_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("after_release_valid", out_valid, 1'b0);
      chk1("after_release_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Reset while in the write-back cycle; reservation also dropped
      issue(4'hA, 8'd9, 1'b0, 4'hF, 32'h0, 4'd2, 8'h01);
      issue(4'h0, 8'd11, 1'b1, 4'hF, 32'h20, 4'd0, 8'h02);
      issue(4'h2, 8'd11, 1'b0, 4'hF, 32'd5, 4'd0, 8'h03);
      rst = 1'b1;
      @(negedge clk);
      chk1("rstwb_bank_req", bank_req, 1'b0);
      chk1("rstwb_bank_we", bank_we, 1'b0);
      chk1("rstwb_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk1("rstwb_in_ready", in_ready, 1'b1);
      chk1("rstwb_out_valid2", out_valid, 1'b0);
      chk32("rstwb_mem11", mem[11], 32'h20);
      @(posedge clk); #1;
      issue(4'hB, 8'd9, 1'b0, 4'hF, 32'h77, 4'd2, 8'h04);
      @(negedge clk);
      chk1("rstsc_valid", out_valid, 1'b1);
      chk32("rstsc_rdata", out_rdata, 32'd1);
      @(posedge clk); #1;
      chk32("rstsc_mem9", mem[9], 32'h55);

      // Randomized traffic against the reference model
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ref_res_v = 1'b0; ref_res_a = '0; ref_res_c = '0;
      exp_q.delete();
      acc_last = 1'b0;
      stall_seen = 1'b0;
      stall_val = '0;
      preload = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!in_valid || acc_last) begin
            if (preload < 16) begin
               in_valid = 1'b1; in_amo = 4'h0; in_wen = 1'b1; in_be = 4'hF;
               in_addr = AW'(preload); in_data = $urandom; in_core = '0;
               in_meta = MW'($urandom);
               preload++;
            end else begin
               in_valid = ($urandom_range(0, 3) != 0);
               case ($urandom_range(0, 7))
                  0, 1:    in_amo = 4'h0;
                  2, 3:    in_amo = 4'($urandom_range(1, 9));
                  4:       in_amo = 4'hA;
                  5:       in_amo = 4'hB;
                  6:       in_amo = 4'($urandom_range(12, 15));
                  default: in_amo = 4'($urandom_range(0, 15));
               endcase
               in_addr = AW'($urandom_range(0, 3));
               in_wen  = 1'($urandom_range(0, 1));
               in_be   = 4'($urandom_range(0, 15));
               in_data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
               in_core = 4'($urandom_range(0, 1));
               in_meta = MW'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         mon_cycle();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         mon_cycle();
         @(posedge clk); #1;
      end
      chk32("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
